// File: rtl/dea_pkg.sv
// Shared types and constants for the rotating-key XOR cipher stream controller.
package dea_pkg;

  localparam int MAX_KEYS  = 4;
  localparam int BYTE_W    = 8;
  localparam int KEY_BUS_W = 32;

  typedef logic [BYTE_W-1:0]    byte_t;
  typedef logic [KEY_BUS_W-1:0] key_bus_t;
  typedef logic [1:0]           state_t;

  localparam state_t ST_LOAD  = 2'd0;
  localparam state_t ST_SYNC  = 2'd1;
  localparam state_t ST_RUN   = 2'd2;
  localparam state_t ST_DRAIN = 2'd3;

endpackage

// File: rtl/dea_stream_ctrl_if.sv
// Key-load, plaintext and ciphertext handshakes of dea_stream_ctrl.
// master = traffic source/sink outside the controller, slave = the controller.
interface dea_stream_ctrl_if;
  import dea_pkg::*;

  logic  key_valid;
  byte_t key_data;
  logic  key_last;
  logic  key_ready;
  logic  s_valid;
  byte_t s_data;
  logic  s_ready;
  logic  m_valid;
  byte_t m_data;
  logic  m_ready;

  modport master (
    output key_valid, key_data, key_last, s_valid, s_data, m_ready,
    input  key_ready, s_ready, m_valid, m_data
  );

  modport slave (
    input  key_valid, key_data, key_last, s_valid, s_data, m_ready,
    output key_ready, s_ready, m_valid, m_data
  );
endinterface

// File: rtl/dea_stream_ctrl.sv
// Sequencer for the rotating-key XOR cipher: loads keys, restarts rotation, streams bytes.
// Optional byte counter output enabled by DEA_STREAM_CTRL_BYTECOUNT_EN.
module dea_stream_ctrl
  import dea_pkg::*;
#(
  parameter int MAX_KEYS_P = MAX_KEYS
`ifdef DEA_STREAM_CTRL_BYTECOUNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              dclk,
  input  logic              reset,
  dea_stream_ctrl_if.slave  bus,
  input  logic              rekey,
  output logic              busy,
  output logic              c_reset,
  output logic              c_kset,
  output byte_t             c_din,
  output logic [2:0]        c_num_keys,
  output key_bus_t          c_keys,
  input  byte_t             c_dout,
`ifdef DEA_STREAM_CTRL_BYTECOUNT_EN
  output logic [CNT_W-1:0]  byte_count,
`endif
  output state_t            dbg_state
);

  // Every channel transfers on the cycle where valid && ready are both high;
  // valid never depends on ready, and a valid byte holds its data until taken.

  localparam logic [1:0] LAST_IDX = 2'(MAX_KEYS_P - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  key_bus_t   keys_q, keys_d;
  logic [2:0] nk_q, nk_d;
  logic       m_valid_q, m_valid_d;
  logic       key_ready, s_ready, fire;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    keys_d    = keys_q;
    nk_d      = nk_q;
    key_ready = 1'b0;
    s_ready   = 1'b0;
    fire      = 1'b0;
    busy      = 1'b1;
    c_reset   = 1'b0;
    c_kset    = 1'b1;
    case (state_q)
      ST_LOAD: begin
        busy      = 1'b0;
        key_ready = 1'b1;
        c_reset   = 1'b1;
        if (bus.key_valid) begin
          keys_d[{idx_q, 3'b000} +: 8] = bus.key_data;
          idx_d = idx_q + 2'd1;
          if (bus.key_last || idx_q == LAST_IDX) begin
            nk_d    = {1'b0, idx_q} + 3'd1;
            state_d = ST_SYNC;
          end
        end
      end
      ST_SYNC: begin
        c_reset = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (rekey) begin
          state_d = m_valid_q ? ST_DRAIN : ST_LOAD;
        end else begin
          s_ready = !m_valid_q || bus.m_ready;
          fire    = bus.s_valid && s_ready;
          c_kset  = !fire;
        end
      end
      ST_DRAIN: begin
        // Also leave if the pending byte was taken on the rekey cycle itself.
        if (!m_valid_q || bus.m_ready) state_d = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
    if (state_d == ST_LOAD && state_q != ST_LOAD) begin
      idx_d = 2'd0;
      nk_d  = 3'd0;
    end
  end

  assign m_valid_d = fire | (m_valid_q & ~bus.m_ready);

  always_ff @(posedge dclk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_LOAD;
      idx_q     <= 2'd0;
      keys_q    <= '0;
      nk_q      <= 3'd0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      keys_q    <= keys_d;
      nk_q      <= nk_d;
      m_valid_q <= m_valid_d;
    end
  end

`ifdef DEA_STREAM_CTRL_BYTECOUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_LOAD && state_d == ST_SYNC) cnt_d = '0;
    else if (fire)                                cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge dclk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign byte_count = cnt_q;
`endif

  assign bus.key_ready = key_ready;
  assign bus.s_ready   = s_ready;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_data    = c_dout;
  assign c_din         = bus.s_data;
  assign c_keys        = keys_q;
  assign c_num_keys    = nk_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_dea_stream_ctrl.sv
// Self-checking bench for dea_stream_ctrl with a behavioural rotating-key XOR cipher.
module tb_dea_stream_ctrl;
  import dea_pkg::*;

  logic       dclk;
  logic       reset;
  logic       rekey;
  logic       busy, c_reset, c_kset;
  logic [7:0] c_din, c_dout;
  logic [2:0] c_num_keys;
  logic [31:0] c_keys;
  state_t     dbg_state;
`ifdef DEA_STREAM_CTRL_BYTECOUNT_EN
  logic [15:0] byte_count;
`endif

  dea_stream_ctrl_if bus ();

  dea_stream_ctrl dut (
    .dclk       (dclk),
    .reset      (reset),
    .bus        (bus),
    .rekey      (rekey),
    .busy       (busy),
    .c_reset    (c_reset),
    .c_kset     (c_kset),
    .c_din      (c_din),
    .c_num_keys (c_num_keys),
    .c_keys     (c_keys),
    .c_dout     (c_dout),
`ifdef DEA_STREAM_CTRL_BYTECOUNT_EN
    .byte_count (byte_count),
`endif
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial dclk = 1'b0;
  always #5 dclk = ~dclk;

  // Stand-in for the cipher: sync active-high reset, kset stalls, key index wraps at num_keys.
  logic [2:0] cidx;
  always @(posedge dclk) begin
    if (c_reset) begin
      c_dout <= 8'h00;
      cidx   <= 3'd0;
    end else if (!c_kset) begin
      c_dout <= c_din ^ c_keys[{cidx[1:0], 3'b000} +: 8];
      cidx   <= (cidx + 3'd1 >= c_num_keys) ? 3'd0 : cidx + 3'd1;
    end
  end

  // ---------------- scoreboard ----------------
  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_keys[$];
  int         model_n = 0;
  int         fired = 0;
  logic [7:0] exp_v;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got=%0h need=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the n-th accepted byte since the last key load is XORed with key[n mod count].
  task automatic push_exp(input logic [7:0] d);
    exp_q.push_back(d ^ model_keys[model_n % model_keys.size()]);
    model_n++;
    fired++;
  endtask

  always @(negedge dclk) begin
    if (reset && bus.m_valid && bus.m_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $error("FAIL sb_extra got=%02h need=none", bus.m_data);
      end else begin
        exp_v = exp_q.pop_front();
        assert (bus.m_data === exp_v) else begin
          fails++;
          $error("FAIL sb_data got=%02h need=%02h", bus.m_data, exp_v);
        end
      end
    end
  end

  // ---------------- driver tasks (enter and leave at posedge + 1) ----------------
  task automatic load_key(input logic [7:0] d, input logic last);
    bit ok = 0;
    bus.key_valid = 1'b1;
    bus.key_data  = d;
    bus.key_last  = last;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge dclk);
      ok = bus.key_ready;
      @(posedge dclk); #1;
    end
    bus.key_valid = 1'b0;
    bus.key_last  = 1'b0;
    if (!ok) begin fails++; tests++; $error("FAIL key_timeout got=0 need=1"); end
    model_keys.push_back(d);
    if (last || model_keys.size() == 4) model_n = 0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    bit ok = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge dclk);
      if (bus.s_ready) begin
        push_exp(d);
        ok = 1;
      end
      @(posedge dclk); #1;
    end
    bus.s_valid = 1'b0;
    if (!ok) begin fails++; tests++; $error("FAIL send_timeout got=0 need=1"); end
  endtask

  task automatic do_rekey();
    bit ok = 0;
    rekey = 1'b1;
    @(negedge dclk);
    chk("rekey_s_ready", bus.s_ready, 0);
    @(posedge dclk); #1;
    rekey = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge dclk);
      ok = bus.key_ready;
      @(posedge dclk); #1;
    end
    if (!ok) begin fails++; tests++; $error("FAIL rekey_timeout got=0 need=1"); end
    model_keys.delete();
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      bus.m_ready = ($urandom_range(0, 3) != 0);
      bus.s_valid = 1'($urandom_range(0, 1));
      bus.s_data  = 8'($urandom);
      @(negedge dclk);
      if (bus.s_valid && bus.s_ready) push_exp(bus.s_data);
      @(posedge dclk); #1;
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge dclk); #1; end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    reset = 1'b0; rekey = 1'b0;
    bus.key_valid = 1'b0; bus.key_data = 8'h00; bus.key_last = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = 8'h00; bus.m_ready = 1'b1;
    repeat (3) @(posedge dclk);
    @(negedge dclk);
    chk("rst_key_ready", bus.key_ready, 1);
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_c_reset", c_reset, 1);
    chk("rst_c_kset", c_kset, 1);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_c_keys", c_keys, 0);
    chk("rst_num_keys", c_num_keys, 0);
    chk("rst_state", dbg_state, ST_LOAD);
    @(posedge dclk); #1;
    reset = 1'b1;
    idle(1);

    // Two keys with key_last, then zeros show the raw key rotation.
    load_key(8'h11, 1'b0);
    load_key(8'h22, 1'b1);
    @(negedge dclk);
    chk("sync_busy", busy, 1);
    chk("sync_key_ready", bus.key_ready, 0);
    chk("sync_c_reset", c_reset, 1);
    chk("sync_s_ready", bus.s_ready, 0);
    @(posedge dclk); #1;
    chk("t1_num_keys", c_num_keys, 2);
    chk("run_c_reset", c_reset, 0);
    repeat (3) send_byte(8'h00);
    idle(2);
    chk("t1_drained", exp_q.size(), 0);
`ifdef DEA_STREAM_CTRL_BYTECOUNT_EN
    chk("t1_byte_count", byte_count, 3);
`endif

    // Four keys without key_last: auto advance after the fourth.
    do_rekey();
    chk("t2_num_keys_clr", c_num_keys, 0);
    load_key(8'hA5, 1'b0);
    load_key(8'h5A, 1'b0);
    load_key(8'hFF, 1'b0);
    load_key(8'h01, 1'b0);
    @(negedge dclk);
    chk("t2_c_keys", c_keys, 32'h01FF5AA5);
    chk("t2_num_keys", c_num_keys, 4);
    chk("t2_sync_key_ready", bus.key_ready, 0);
`ifdef DEA_STREAM_CTRL_BYTECOUNT_EN
    chk("t2_count_clr", byte_count, 0);
`endif
    @(posedge dclk); #1;
    repeat (5) send_byte(8'hFF);
    idle(2);
    chk("t2_drained", exp_q.size(), 0);

    // Single key, downstream stalled: output holds, no key skipped.
    do_rekey();
    load_key(8'h3C, 1'b1);
    idle(1);
    bus.m_ready = 1'b0;
    send_byte(8'h0F);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h0F;
    for (int i = 0; i < 4; i++) begin
      @(negedge dclk);
      chk("hold_m_valid", bus.m_valid, 1);
      chk("hold_m_data", bus.m_data, 8'h33);
      chk("hold_s_ready", bus.s_ready, 0);
      @(posedge dclk); #1;
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    send_byte(8'h0F);
    idle(2);
    chk("t3_drained", exp_q.size(), 0);

    // Randomized key sets and traffic.
    for (int r = 0; r < 4; r++) begin
      int nk;
      do_rekey();
      nk = $urandom_range(1, 4);
      for (int k = 0; k < nk; k++)
        load_key(8'($urandom), (k == nk - 1) && (nk < 4 || ($urandom_range(0, 1) == 1)));
      idle(1);
      rand_cycles(200);
      idle(3);
      chk("rand_drained", exp_q.size(), 0);
    end

    // Rekey while an output is pending, with a simultaneous plaintext offer.
    do_rekey();
    load_key(8'h11, 1'b0);
    load_key(8'h22, 1'b1);
    idle(1);
    send_byte(8'h00);
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hAA;
    rekey = 1'b1;
    @(negedge dclk);
    chk("t4_rekey_wins", bus.s_ready, 0);
    @(posedge dclk); #1;
    rekey = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge dclk);
      chk("drain_key_ready", bus.key_ready, 0);
      chk("drain_busy", busy, 1);
      chk("drain_m_valid", bus.m_valid, 1);
      chk("drain_c_kset", c_kset, 1);
      chk("drain_s_ready", bus.s_ready, 0);
      chk("drain_state", dbg_state, ST_DRAIN);
      @(posedge dclk); #1;
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    idle(1);
    @(negedge dclk);
    chk("t4_key_ready", bus.key_ready, 1);
    chk("t4_num_keys_clr", c_num_keys, 0);
    chk("t4_m_valid", bus.m_valid, 0);
    @(posedge dclk); #1;
    model_keys.delete();
    load_key(8'h77, 1'b1);
    idle(1);
    send_byte(8'h00);
    idle(2);
    chk("t4_drained", exp_q.size(), 0);

    // Asynchronous reset while a byte is in flight.
    bus.m_ready = 1'b0;
    send_byte(8'h42);
    #2 reset = 1'b0;
    #1;
    chk("arst_m_valid", bus.m_valid, 0);
    chk("arst_key_ready", bus.key_ready, 1);
    chk("arst_c_reset", c_reset, 1);
    chk("arst_busy", busy, 0);
`ifdef DEA_STREAM_CTRL_BYTECOUNT_EN
    chk("arst_byte_count", byte_count, 0);
`endif
    exp_q.delete();
    @(posedge dclk); #1;
    reset = 1'b1;
    bus.m_ready = 1'b1;
    model_keys.delete();
    idle(1);

`ifdef DEA_STREAM_CTRL_BYTECOUNT_EN
    // Counter wrap: 70000 back-to-back bytes.
    begin
      int n = 0;
      load_key(8'h5A, 1'b1);
      idle(1);
      bus.s_valid = 1'b1;
      bus.s_data  = 8'h00;
      for (int i = 0; i < 72000 && n < 70000; i++) begin
        @(negedge dclk);
        if (bus.s_ready) begin push_exp(8'h00); n++; end
        @(posedge dclk); #1;
      end
      bus.s_valid = 1'b0;
      chk("bulk_fires", n, 70000);
      chk("bulk_byte_count", byte_count, 4464);
      idle(2);
      chk("bulk_drained", exp_q.size(), 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
